// File: rtl/prog_mem_loader_pkg.sv
// Shared types and constants for the program-memory loader: FSM encoding and
// the byte-lane count derived from the instruction word width.
package prog_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned lane_count(input int unsigned width);
    return width / BYTE_W;
  endfunction

  localparam int unsigned LANES = lane_count(32);

endpackage

// File: rtl/prog_mem_loader_byte_word_assembler.sv
// Collects stream bytes into a little-endian word; lane 0 lands in the low byte.
// word_ready flags the cycle in which the final lane is being accepted.
module byte_word_assembler
  import prog_mem_loader_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int LANES_W = lane_count(WIDTH),
  localparam int CNT_W = (LANES_W > 1) ? $clog2(LANES_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             byte_we,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             word_ready
);

  logic [WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign word_ready = byte_we && (cnt_q == CNT_W'(LANES_W - 1));
  assign word       = word_q;
  assign byte_cnt   = cnt_q;

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (byte_we) begin
      word_d[cnt_q*BYTE_W +: BYTE_W] = byte_in;
      cnt_d = word_ready ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Program-memory writer: assembles streamed bytes into words, writes them from
// address 0 upward while holding the core, and reports count and XOR checksum.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_wen,
  output logic [ADD_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 cpu_hold,
  output logic                 load_complete,
  output logic                 mem_full,
  output logic [ADD_WIDTH:0]   words_loaded,
  output logic [WIDTH-1:0]     checksum
);

  localparam int LANES_W = lane_count(WIDTH);
  localparam int CNT_W   = (LANES_W > 1) ? $clog2(LANES_W) : 1;
  localparam int WL_W    = ADD_WIDTH + 1;

  state_e               state_q, state_d;
  logic                 armed_q, armed_d;
  logic [ADD_WIDTH-1:0] addr_q, addr_d;
  logic [ADD_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [WIDTH-1:0]     data_hold_q, data_hold_d;
  logic [WL_W-1:0]      wl_q, wl_d;
  logic [WIDTH-1:0]     cks_q, cks_d;
  logic                 full_q, full_d;

  logic             asm_clear, accept, word_ready;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] byte_cnt;

  assign byte_ready    = (state_q == ST_LOAD) && load_en;
  assign accept        = byte_valid && byte_ready;
  assign mem_wen       = (state_q == ST_WRITE);
  assign cpu_hold      = (state_q != ST_IDLE);
  assign load_complete = (state_q == ST_DONE);
  // Address/data are live during the write and frozen afterwards.
  assign mem_addr      = mem_wen ? addr_q : addr_hold_q;
  assign mem_wdata     = mem_wen ? word : data_hold_q;
  assign mem_full      = full_q;
  assign words_loaded  = wl_q;
  assign checksum      = cks_q;

  byte_word_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_we    (accept),
    .byte_in    (byte_in),
    .word       (word),
    .byte_cnt   (byte_cnt),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    addr_d      = addr_q;
    addr_hold_d = addr_hold_q;
    data_hold_d = data_hold_q;
    wl_d        = wl_q;
    cks_d       = cks_q;
    full_d      = full_q;
    asm_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A session only starts after load_en has been seen low here.
        if (!load_en) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d   = ST_LOAD;
          armed_d   = 1'b0;
          addr_d    = '0;
          wl_d      = '0;
          cks_d     = '0;
          full_d    = 1'b0;
          asm_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        if (word_ready)        state_d = ST_WRITE;
        else if (!load_en)     state_d = (byte_cnt == '0) ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        addr_hold_d = addr_q;
        data_hold_d = word;
        wl_d        = wl_q + WL_W'(1);
        cks_d       = cks_q ^ word;
        asm_clear   = 1'b1;
        if (addr_q == ADD_WIDTH'(DEPTH - 1)) begin
          full_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADD_WIDTH'(1);
          state_d = load_en ? ST_LOAD : ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      addr_q      <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
      wl_q        <= '0;
      cks_q       <= '0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      addr_q      <= addr_d;
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
      wl_q        <= wl_d;
      cks_q       <= cks_d;
      full_q      <= full_d;
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: cycle-exact vector table for the basic and
// partial-tail sessions, plus handshake-driven multi-word, back-pressure, full and reset cases.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_complete;
  logic        mem_full;
  logic [8:0]  words_loaded;
  logic [31:0] checksum;

  prog_mem_loader #(.WIDTH(32), .ADD_WIDTH(8), .DEPTH(256)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_en       (load_en),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .load_complete (load_complete),
    .mem_full      (mem_full),
    .words_loaded  (words_loaded),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        le, bv;
    logic [7:0]  b;
    logic        br, wen;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        hold, lc, full;
    logic [8:0]  wl;
    logic [31:0] cks;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wen_cnt = 0;
  int          lc_cnt = 0;
  int          br_viol = 0;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wen) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wen_cnt++;
    end
    if (load_complete) lc_cnt++;
    if ((mem_wen || load_complete) && byte_ready) br_viol++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic v(input string n, input logic le, bv, input logic [7:0] b,
                   input logic br, wen, input logic [7:0] addr, input logic [31:0] wdata,
                   input logic hold, lc, full, input logic [8:0] wl, input logic [31:0] cks);
    vec_t t;
    t.name = n; t.le = le; t.bv = bv; t.b = b; t.br = br; t.wen = wen; t.addr = addr;
    t.wdata = wdata; t.hold = hold; t.lc = lc; t.full = full; t.wl = wl; t.cks = cks;
    vecs.push_back(t);
  endtask

  function automatic logic [85:0] outs();
    return {byte_ready, mem_wen, mem_addr, mem_wdata, cpu_hold, load_complete,
            mem_full, words_loaded, checksum};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clk);
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) check("byte_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic start_session();
    @(posedge clk); #1 load_en = 1'b0;
    @(posedge clk); #1 load_en = 1'b1;
  endtask

  task automatic end_session();
    int n = 0;
    load_en = 1'b0;
    @(negedge clk);
    while (!load_complete && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", load_complete, 1'b1);
    @(negedge clk);
    check("hold_after_done", cpu_hold, 1'b0);
  endtask

  function automatic logic [31:0] full_word(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {k, ~k, k + 8'h5A, k ^ 8'hC3};
  endfunction

  initial begin
    logic [31:0] exp_cks;
    int errs;

    rst = 1'b0; load_en = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    #12;
    check("reset_outputs", outs(), 86'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Basic word 0x00500513.
    v("b_arm",   0,0,8'h00, 0,0,8'd0,32'h0,        0,0,0,9'd0,32'h0);
    v("b_start", 1,0,8'h00, 0,0,8'd0,32'h0,        0,0,0,9'd0,32'h0);
    v("b_l0",    1,1,8'h13, 1,0,8'd0,32'h0,        1,0,0,9'd0,32'h0);
    v("b_l1",    1,1,8'h05, 1,0,8'd0,32'h0,        1,0,0,9'd0,32'h0);
    v("b_l2",    1,1,8'h50, 1,0,8'd0,32'h0,        1,0,0,9'd0,32'h0);
    v("b_l3",    1,1,8'h00, 1,0,8'd0,32'h0,        1,0,0,9'd0,32'h0);
    v("b_write", 1,0,8'h00, 0,1,8'd0,32'h00500513, 1,0,0,9'd0,32'h0);
    v("b_drop",  0,0,8'h00, 0,0,8'd0,32'h00500513, 1,0,0,9'd1,32'h00500513);
    v("b_done",  0,0,8'h00, 0,0,8'd0,32'h00500513, 1,1,0,9'd1,32'h00500513);
    v("b_idle",  0,0,8'h00, 0,0,8'd0,32'h00500513, 0,0,0,9'd1,32'h00500513);
    // Partial tail, with bytes offered during WRITE and on the load_en drop cycle.
    v("p_start", 1,0,8'h00, 0,0,8'd0,32'h00500513, 0,0,0,9'd1,32'h00500513);
    v("p_l0",    1,1,8'hAA, 1,0,8'd0,32'h00500513, 1,0,0,9'd0,32'h0);
    v("p_l1",    1,1,8'hBB, 1,0,8'd0,32'h00500513, 1,0,0,9'd0,32'h0);
    v("p_l2",    1,1,8'hCC, 1,0,8'd0,32'h00500513, 1,0,0,9'd0,32'h0);
    v("p_l3",    1,1,8'hDD, 1,0,8'd0,32'h00500513, 1,0,0,9'd0,32'h0);
    v("p_write", 1,1,8'h99, 0,1,8'd0,32'hDDCCBBAA, 1,0,0,9'd0,32'h0);
    v("p_tail",  1,1,8'hEE, 1,0,8'd0,32'hDDCCBBAA, 1,0,0,9'd1,32'hDDCCBBAA);
    v("p_drop",  0,1,8'h55, 0,0,8'd0,32'hDDCCBBAA, 1,0,0,9'd1,32'hDDCCBBAA);
    v("p_wr2",   0,0,8'h00, 0,1,8'd1,32'h000000EE, 1,0,0,9'd1,32'hDDCCBBAA);
    v("p_done",  0,0,8'h00, 0,0,8'd1,32'h000000EE, 1,1,0,9'd2,32'hDDCCBB44);
    v("p_idle",  0,0,8'h00, 0,0,8'd1,32'h000000EE, 0,0,0,9'd2,32'hDDCCBB44);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      load_en = vecs[i].le; byte_valid = vecs[i].bv; byte_in = vecs[i].b;
      @(negedge clk);
      check(vecs[i].name, outs(),
            {vecs[i].br, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
             vecs[i].lc, vecs[i].full, vecs[i].wl, vecs[i].cks});
    end
    byte_valid = 1'b0;

    // Multi-word session.
    wr_addr.delete(); wr_data.delete();
    start_session();
    send_word(32'h11111111); send_word(32'h22222222); send_word(32'h44444444);
    end_session();
    check("multi_nwr", wr_addr.size(), 3);
    if (wr_addr.size() == 3)
      check("multi_writes", {wr_addr[0], wr_addr[1], wr_addr[2], wr_data[0], wr_data[1], wr_data[2]},
            {8'd0, 8'd1, 8'd2, 32'h11111111, 32'h22222222, 32'h44444444});
    check("multi_status", {words_loaded, checksum, mem_full}, {9'd3, 32'h77777777, 1'b0});

    // Back-pressure: byte_valid stays asserted across WRITE/DONE.
    wr_addr.delete(); wr_data.delete(); br_viol = 0;
    exp_cks = '0;
    start_session();
    for (int w = 0; w < 4; w++) begin
      send_word(32'h0D0C0B0A + 32'h10101010 * w);
      byte_valid = 1'b1;
      exp_cks ^= 32'h0D0C0B0A + 32'h10101010 * w;
    end
    end_session();
    byte_valid = 1'b0;
    check("bp_ready_low", br_viol, 0);
    errs = 0;
    foreach (wr_data[i])
      if (wr_data[i] !== 32'h0D0C0B0A + 32'h10101010 * i || wr_addr[i] !== 8'(i)) errs++;
    check("bp_writes", {wr_addr.size(), errs}, {32'd4, 32'd0});
    check("bp_status", {words_loaded, checksum}, {9'd4, exp_cks});

    // Fill all 256 locations, then keep offering bytes with load_en high.
    wr_addr.delete(); wr_data.delete(); wen_cnt = 0; lc_cnt = 0;
    exp_cks = '0;
    start_session();
    for (int i = 0; i < 256; i++) begin
      send_word(full_word(i));
      exp_cks ^= full_word(i);
    end
    byte_valid = 1'b1; byte_in = 8'h77;
    repeat (20) @(posedge clk);
    #1 byte_valid = 1'b0;
    @(negedge clk);
    check("full_nwr", {wen_cnt, lc_cnt}, {32'd256, 32'd1});
    errs = 0;
    foreach (wr_data[i])
      if (wr_data[i] !== full_word(i) || wr_addr[i] !== 8'(i)) errs++;
    check("full_data", errs, 0);
    check("full_status", {cpu_hold, mem_full, words_loaded, checksum, mem_addr},
          {1'b0, 1'b1, 9'd256, exp_cks, 8'd255});
    @(posedge clk); #1 load_en = 1'b0;
    @(posedge clk); #1 load_en = 1'b1;
    @(negedge clk); @(negedge clk);
    check("full_rearm", {cpu_hold, mem_full, words_loaded}, {1'b1, 1'b0, 9'd0});
    end_session();

    // Reset in the middle of a word, then a clean session.
    start_session();
    send_byte(8'h11); send_byte(8'h22);
    #3 rst = 1'b0;
    #1 check("reset_midload", outs(), 86'd0);
    load_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    wr_addr.delete(); wr_data.delete();
    start_session();
    send_word(32'hD4C3B2A1);
    end_session();
    check("post_reset_wr", wr_addr.size(), 1);
    if (wr_addr.size() == 1)
      check("post_reset_word", {wr_addr[0], wr_data[0]}, {8'd0, 32'hD4C3B2A1});
    check("post_reset_status", {words_loaded, checksum}, {9'd1, 32'hD4C3B2A1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
